// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit buffer: slave/master register offsets,
// the LSR transmitter-idle bit and the drain FSM state encoding.
package uart_tx_fifo_pkg;

  localparam logic [2:0] OFF_TXDATA    = 3'b000;
  localparam logic [2:0] OFF_STATUS    = 3'b001;

  // Mini UART register port offsets (word address bits [4:2])
  localparam logic [2:0] OFF_UART_DATA = 3'b000;
  localparam logic [2:0] OFF_UART_LSR  = 3'b101;

  localparam int LSR_TS_BIT = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_POLL  = 2'b01,
    ST_WRITE = 2'b10,
    ST_HOLD  = 2'b11
  } tx_state_e;

  function automatic logic [31:0] pack_status(input logic       ovf,
                                              input logic [5:0] count,
                                              input logic       full,
                                              input logic       empty);
    return {23'd0, ovf, count, full, empty};
  endfunction

endpackage

// File: rtl/sync_fifo8.sv
// Byte-wide synchronous FIFO, 2^DEPTH_LOG2 entries. A push while full is ignored;
// a same-cycle pop does not make room for it.
module sync_fifo8 #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  CLK_I,
  input  logic                  RST_I,
  input  logic                  push,
  input  logic                  pop,
  input  logic [7:0]            wdata,
  output logic [7:0]            rdata,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1'b1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = (DEPTH_LOG2)'(1'b1);

  logic [7:0]            mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [DEPTH_LOG2:0]   count_r;
  logic                  push_ok_s;
  logic                  pop_ok_s;

  assign full      = (count_r == CNT_FULL);
  assign empty     = (count_r == '0);
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign rdata     = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Storage array; contents are don't-care after reset
  always_ff @(posedge CLK_I) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers wrap naturally at 2^DEPTH_LOG2; count tracks occupancy
  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// CPU-side transmit buffer in front of the Mini UART: buffers bytes and drains
// them one at a time whenever the UART line status reports the transmitter idle.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int GUARD      = 4
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic [4:2]  ADD_I,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  input  logic        STB_I,
  input  logic        WE_I,
  output logic [4:2]  M_ADD_O,
  output logic [31:0] M_DAT_O,
  input  logic [31:0] M_DAT_I,
  output logic        M_STB_O,
  output logic        M_WE_O,
  output logic        tx_empty_o
);

  localparam logic [3:0] GUARD_LOAD = 4'(GUARD - 1);

  tx_state_e           state_r;
  tx_state_e           state_nxt_s;
  logic [3:0]          guard_r;
  logic [3:0]          guard_nxt_s;
  logic                ovf_r;
  logic                push_req_s;
  logic                stat_wr_s;
  logic                pop_s;
  logic [7:0]          fifo_rdata_s;
  logic [DEPTH_LOG2:0] fifo_count_s;
  logic                fifo_full_s;
  logic                fifo_empty_s;
  logic                unused_s;

  assign push_req_s = STB_I & WE_I & (ADD_I == OFF_TXDATA);
  assign stat_wr_s  = STB_I & WE_I & (ADD_I == OFF_STATUS);
  assign pop_s      = (state_r == ST_WRITE);
  assign tx_empty_o = fifo_empty_s & (state_r == ST_IDLE);
  assign unused_s   = ^{DAT_I[31:8], M_DAT_I[31:LSR_TS_BIT+1], M_DAT_I[LSR_TS_BIT-1:0]};

  sync_fifo8 #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .CLK_I (CLK_I),
    .RST_I (RST_I),
    .push  (push_req_s),
    .pop   (pop_s),
    .wdata (DAT_I[7:0]),
    .rdata (fifo_rdata_s),
    .count (fifo_count_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Sticky overflow: set by a push into a full FIFO, cleared by any STATUS write
  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      ovf_r <= 1'b0;
    end else if (stat_wr_s) begin
      ovf_r <= 1'b0;
    end else if (push_req_s && fifo_full_s) begin
      ovf_r <= 1'b1;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  // Drain FSM and guard counter state
  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      state_r <= ST_IDLE;
      guard_r <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      guard_r <= guard_nxt_s;
    end
  end

  // Next-state logic; HOLD lasts GUARD cycles so the UART ts bit has time to drop
  always_comb begin
    state_nxt_s = state_r;
    guard_nxt_s = guard_r;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          state_nxt_s = ST_POLL;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_POLL: begin
        if (M_DAT_I[LSR_TS_BIT]) begin
          state_nxt_s = ST_WRITE;
        end else begin
          state_nxt_s = ST_POLL;
        end
      end
      ST_WRITE: begin
        guard_nxt_s = GUARD_LOAD;
        state_nxt_s = ST_HOLD;
      end
      ST_HOLD: begin
        if (guard_r == 4'd0) begin
          if (!fifo_empty_s) begin
            state_nxt_s = ST_POLL;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          guard_nxt_s = guard_r - 4'd1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        guard_nxt_s = 4'd0;
      end
    endcase
  end

  // UART master port, decoded from the state register only
  always_comb begin
    M_STB_O = 1'b0;
    M_WE_O  = 1'b0;
    M_ADD_O = 3'b000;
    M_DAT_O = 32'd0;
    case (state_r)
      ST_POLL: begin
        M_STB_O = 1'b1;
        M_ADD_O = OFF_UART_LSR;
      end
      ST_WRITE: begin
        M_STB_O = 1'b1;
        M_WE_O  = 1'b1;
        M_ADD_O = OFF_UART_DATA;
        M_DAT_O = {24'd0, fifo_rdata_s};
      end
      ST_IDLE, ST_HOLD: begin
        M_STB_O = 1'b0;
      end
      default: begin
        M_STB_O = 1'b0;
      end
    endcase
  end

  // CPU read mux; only STATUS returns data
  always_comb begin
    DAT_O = 32'd0;
    if (ADD_I == OFF_STATUS) begin
      DAT_O = pack_status(ovf_r, 6'(fifo_count_s), fifo_full_s, fifo_empty_s);
    end else begin
      DAT_O = 32'd0;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: queue-based reference model of the FIFO,
// scoreboard monitor on the UART master port, directed cases plus random bursts.
module tb_uart_tx_fifo;
  import uart_tx_fifo_pkg::*;

  localparam int DL2   = 4;
  localparam int DEPTH = 16;
  localparam int GUARD = 4;

  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b0;
  logic [4:2]  ADD_I;
  logic [31:0] DAT_I;
  logic [31:0] DAT_O;
  logic        STB_I;
  logic        WE_I;
  logic [4:2]  M_ADD_O;
  logic [31:0] M_DAT_O;
  logic [31:0] M_DAT_I;
  logic        M_STB_O;
  logic        M_WE_O;
  logic        tx_empty_o;

  logic        ts = 1'b0;
  logic [31:0] noise = 32'd0;
  bit          ts_rand = 1'b0;
  bit          mon_en = 1'b0;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          wr_cnt = 0;
  int          last_wr_cyc = -1;
  int          wr_cyc_q[$];
  logic [7:0]  exp_q[$];
  logic        ovf_m = 1'b0;
  logic        prev_we = 1'b0;

  assign M_DAT_I = {noise[31:6], ts, noise[4:0]};

  uart_tx_fifo #(.DEPTH_LOG2(DL2), .GUARD(GUARD)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .ADD_I(ADD_I), .DAT_I(DAT_I), .DAT_O(DAT_O),
    .STB_I(STB_I), .WE_I(WE_I), .M_ADD_O(M_ADD_O), .M_DAT_O(M_DAT_O),
    .M_DAT_I(M_DAT_I), .M_STB_O(M_STB_O), .M_WE_O(M_WE_O), .tx_empty_o(tx_empty_o)
  );

  always #5 CLK_I = ~CLK_I;

  always @(posedge CLK_I) cyc <= cyc + 1;

  always @(negedge CLK_I) begin
    noise = $urandom();
    if (ts_rand) ts = ($urandom_range(0, 3) != 0);
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic logic [31:0] status_exp();
    int n;
    n = exp_q.size();
    return {23'd0, ovf_m, 6'(n), (n == DEPTH), (n == 0)};
  endfunction

  // Scoreboard monitor: samples mid-cycle, after the driver has acted on this cycle
  always begin
    @(negedge CLK_I);
    #2;
    if (mon_en) begin
      if (M_WE_O === 1'b1) begin
        chk("wr_addr", {29'd0, M_ADD_O}, {29'd0, OFF_UART_DATA});
        chk("wr_stb", {31'd0, M_STB_O}, 32'd1);
        chk("wr_not_adjacent", {31'd0, prev_we}, 32'd0);
        if (last_wr_cyc >= 0) chk("wr_spacing_min", {31'd0, (cyc - last_wr_cyc) >= GUARD + 2}, 32'd1);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL wr_unexpected: got byte 0x%0h, expected no write (cycle %0d)", M_DAT_O, cyc);
        end else begin
          chk("wr_data", M_DAT_O, {24'd0, exp_q.pop_front()});
        end
        wr_cnt++;
        last_wr_cyc = cyc;
        wr_cyc_q.push_back(cyc);
      end else if (M_STB_O === 1'b1) begin
        chk("poll_addr", {29'd0, M_ADD_O}, {29'd0, OFF_UART_LSR});
      end else begin
        chk("quiet_m_outputs", {28'd0, M_WE_O, M_ADD_O} | M_DAT_O, 32'd0);
      end
      prev_we = M_WE_O;
    end
  end

  task automatic idle_cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge CLK_I);
  endtask

  task automatic push(input logic [7:0] b);
    logic [31:0] tmp;
    tmp = $urandom();
    ADD_I = OFF_TXDATA;
    DAT_I = {tmp[31:8], b};
    STB_I = 1'b1;
    WE_I  = 1'b1;
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else ovf_m = 1'b1;
    @(negedge CLK_I);
    STB_I = 1'b0;
    WE_I  = 1'b0;
  endtask

  task automatic read_status(input string nm);
    ADD_I = OFF_STATUS;
    STB_I = 1'b1;
    WE_I  = 1'b0;
    #1;
    chk(nm, DAT_O, status_exp());
    @(negedge CLK_I);
    STB_I = 1'b0;
  endtask

  task automatic write_status();
    ADD_I = OFF_STATUS;
    DAT_I = $urandom();
    STB_I = 1'b1;
    WE_I  = 1'b1;
    ovf_m = 1'b0;
    @(negedge CLK_I);
    STB_I = 1'b0;
    WE_I  = 1'b0;
  endtask

  task automatic read_other();
    logic [2:0] a;
    a = 3'($urandom_range(0, 6));
    if (a != 3'd0) a = a + 3'd1;
    ADD_I = a;
    STB_I = 1'b1;
    WE_I  = 1'b0;
    #1;
    chk("other_read_zero", DAT_O, 32'd0);
    @(negedge CLK_I);
    STB_I = 1'b0;
  endtask

  task automatic wait_write(input int budget, input string nm, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (M_WE_O === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK_I);
    end
    chk(nm, {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_drain(input int budget, input string nm);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (tx_empty_o === 1'b1 && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
      @(negedge CLK_I);
    end
    chk(nm, {31'd0, done}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  s;
    int  t;
    int  w;
    bit  ok;
    bit  found;
    int  n;
    ADD_I = 3'b000;
    DAT_I = 32'd0;
    STB_I = 1'b0;
    WE_I  = 1'b0;
    RST_I = 1'b0;

    // Reset: two cycles low, then release
    idle_cyc(2);
    RST_I = 1'b1;
    mon_en = 1'b1;
    chk("rst_m_stb", {31'd0, M_STB_O}, 32'd0);
    chk("rst_m_we", {31'd0, M_WE_O}, 32'd0);
    chk("rst_m_add_dat", {29'd0, M_ADD_O} | M_DAT_O, 32'd0);
    chk("rst_tx_empty", {31'd0, tx_empty_o}, 32'd1);
    read_status("rst_status");
    read_other();

    // Single byte with an idle UART
    ts = 1'b1;
    s = wr_cnt;
    push(8'h41);
    wait_write(20, "single_write_seen", ok);
    if (ok) begin
      found = 1'b0;
      for (int k = 0; k < GUARD + 1; k++) begin
        @(negedge CLK_I);
        if (tx_empty_o === 1'b1) begin
          found = 1'b1;
          break;
        end
      end
      chk("single_empty_within_guard", {31'd0, found}, 32'd1);
    end
    wait_drain(50, "single_drain");
    chk("single_write_count", wr_cnt - s, 32'd1);

    // Busy UART: ts low for 50 cycles, then one-cycle POLL-to-WRITE
    ts = 1'b0;
    s = wr_cnt;
    push(8'h55);
    idle_cyc(50);
    chk("busy_no_write", wr_cnt - s, 32'd0);
    chk("busy_polling", {31'd0, M_STB_O}, 32'd1);
    ts = 1'b1;
    t = cyc;
    wait_write(10, "busy_write_seen", ok);
    if (ok) chk("busy_write_latency", cyc - t, 32'd1);
    wait_drain(50, "busy_drain");

    // Full and overflow with the UART held busy
    ts = 1'b0;
    s = wr_cnt;
    for (int i = 0; i < DEPTH + 1; i++) push(8'($urandom()));
    read_status("full_status");
    chk("full_status_value", status_exp(), 32'h142);
    write_status();
    read_status("ovf_cleared_status");
    ts = 1'b1;
    wait_drain(400, "full_drain");
    chk("full_write_count", wr_cnt - s, DEPTH);

    // Ordering and pacing, back-to-back pushes
    wr_cyc_q.delete();
    s = wr_cnt;
    for (int i = 0; i < DEPTH; i++) push(8'(i));
    wait_drain(400, "order_drain");
    chk("order_write_count", wr_cnt - s, DEPTH);
    if (wr_cyc_q.size() == DEPTH) begin
      for (int i = 1; i < DEPTH; i++) chk("order_spacing", wr_cyc_q[i] - wr_cyc_q[i-1], GUARD + 2);
    end

    // Push in the same cycle as a WRITE pop: count unchanged
    ts = 1'b0;
    for (int i = 0; i < 3; i++) push(8'($urandom()));
    read_status("pp_before");
    ts = 1'b1;
    wait_write(10, "pp_write_seen", ok);
    if (ok) begin
      push(8'($urandom()));
      read_status("pp_after");
    end

    // Reset asserted on a WRITE cycle
    wait_write(40, "rstw_write_seen", ok);
    RST_I = 1'b0;
    @(negedge CLK_I);
    RST_I = 1'b1;
    exp_q.delete();
    ovf_m = 1'b0;
    last_wr_cyc = -1;
    s = wr_cnt;
    idle_cyc(30);
    chk("rstw_no_write", wr_cnt - s, 32'd0);
    chk("rstw_tx_empty", {31'd0, tx_empty_o}, 32'd1);
    read_status("rstw_status");

    // Random bursts with a randomly busy UART
    ts_rand = 1'b1;
    for (int b = 0; b < 6; b++) begin
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) begin
        push(8'($urandom()));
        w = $urandom_range(0, 2);
        if (w == 2) read_other();
        else idle_cyc(w);
      end
      wait_drain(3000, "burst_drain");
      read_status("burst_status");
    end
    ts_rand = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Bus-side transmit buffer that sits directly upstream of the Mini UART. The CPU writes bytes into a 2^DEPTH_LOG2-entry FIFO at full bus speed. A drain FSM acts as bus master on the Mini UART register port: it polls the UART line status register and writes one byte into the UART data register each time the transmitter reports idle. This removes software busy-waiting on the UART.

## Interface
Parameters:
- DEPTH_LOG2, 4: FIFO depth is 2^DEPTH_LOG2 entries of 8 bits.
- GUARD, 4: idle cycles after each UART write before the LSR is polled again; covers the delay before the UART's ts bit drops. Legal range 2..15.

Ports:
- CLK_I  in  1  clock; the same clock as the Mini UART.
- RST_I  in  1  reset; synchronous, active-low.
- ADD_I  in  [4:2]  CPU slave word address: 3'b000 = TXDATA, 3'b001 = STATUS.
- DAT_I  in  32  CPU write data.
- DAT_O  out  32  CPU read data (combinational).
- STB_I  in  1  CPU strobe.
- WE_I  in  1  CPU write enable.
- M_ADD_O  out  [4:2]  address to the UART: `OFF_UART_LSR or `OFF_UART_DATA.
- M_DAT_O  out  32  write data to the UART: {24'b0, byte}.
- M_DAT_I  in  32  UART read data; combinational in the same cycle as M_ADD_O.
- M_STB_O  out  1  UART strobe.
- M_WE_O  out  1  UART write enable.
- tx_empty_o  out  1  high when the FIFO is empty and the FSM is in IDLE.

## Operation
- Push: STB_I & WE_I & ADD_I==TXDATA pushes DAT_I[7:0]. If the FIFO is full, the byte is dropped and the sticky overflow bit is set.
- Push cycles: each strobed write cycle counts as one push. The CPU issues single-cycle writes.
- STATUS read: DAT_O = {23'b0, ovf, count[DEPTH_LOG2:0] zero-extended to 6 bits, full, empty}, packed LSB-first as empty = bit0, full = bit1, count = bits[7:2], ovf = bit8.
- STATUS write: any write to STATUS clears ovf.
- Other reads: DAT_O = 0 for every address other than STATUS.
- Full/empty rules: full when count == 2^DEPTH_LOG2; empty when count == 0. Pointers wrap modulo 2^DEPTH_LOG2. count is DEPTH_LOG2+1 bits wide.
- Simultaneous push and pop: both take effect and count is unchanged. A push is accepted only if the FIFO was not full at the start of the cycle; a same-cycle pop does not make room.
- FSM states: IDLE, POLL, WRITE, HOLD.
  - IDLE: all M_* outputs low. If the FIFO is not empty, go to POLL.
  - POLL: M_STB_O=1, M_WE_O=0, M_ADD_O=`OFF_UART_LSR. If M_DAT_I[5] (ts) is 1, go to WRITE; otherwise stay in POLL.
  - WRITE: exactly one cycle with M_STB_O=1, M_WE_O=1, M_ADD_O=`OFF_UART_DATA, M_DAT_O = head byte. The FIFO pops this cycle. Load the guard counter with GUARD-1 and go to HOLD.
  - HOLD: M_* outputs low. Decrement the guard counter; at 0 go to POLL if the FIFO is not empty, else IDLE.
- UART protocol constraints:
  - The FSM never asserts M_WE_O in consecutive cycles; the UART load logic needs single-cycle write pulses.
  - The FSM never writes to any UART address other than DATA.
- Reset values (RST_I low at a clock edge):
  - Pointers, count and ovf = 0.
  - FSM = IDLE, guard counter = 0.
  - All M_* outputs = 0; tx_empty_o = 1.
  - FIFO RAM contents are don't-care.
- Reset mid-operation: reset in any state, including WRITE, returns the block to IDLE with the FIFO flushed. No further UART writes occur after that edge.

## Timing
- Push latency: a push at edge N makes empty=0 visible at STATUS after edge N. The FSM leaves IDLE at edge N+1.
- Poll latency: POLL-to-WRITE is one cycle when ts=1.
- Minimum byte-to-byte UART write spacing: 1 (WRITE) + GUARD (HOLD) + 1 (POLL) cycles.
- M_* outputs are registered or decoded from state only; M_DAT_O comes from the FIFO head.
- Reads: DAT_O is combinational from ADD_I and registered state. The block has no wait states.

## Structure
- Shared package/header (extending head_uart.v):
  - FIFO register offsets (TXDATA, STATUS).
  - LSR ts bit index (5).
  - FSM state encodings.
- Sub-module `sync_fifo8`, parameterised by DEPTH_LOG2: RAM, pointers, count, full, empty, push/pop.
- The top level holds the slave decode, the ovf bit, the FSM and the guard counter.

## Test plan
- Reset: drive RST_I=0 for 2 cycles, then release → STATUS reads 0x001 and all M_* outputs are 0.
- Single byte: push 0x41 with a UART model returning ts=1 → exactly one cycle with M_WE_O=1 at `OFF_UART_DATA, M_DAT_O=0x00000041. After that tx_empty_o=1 within GUARD+1 cycles.
- Busy UART: push 0x55 while the model holds ts=0 for 50 cycles → FSM stays in POLL with no writes. The write occurs one cycle after ts rises.
- Full and overflow (DEPTH_LOG2=4, ts=0): push 17 bytes → STATUS = 0x142 (ovf=1, count=16, full=1). The 17th byte is never sent. A write to STATUS then reads back 0x042.
- Ordering and pacing: push 0x00..0x0F back-to-back with ts=1 → UART receives 0x00..0x0F in order. Consecutive writes are spaced GUARD+2 cycles apart, and no two M_WE_O cycles are adjacent.
- Simultaneous push/pop and reset mid-WRITE: push during a WRITE cycle → count unchanged. Assert reset on a WRITE cycle → no further M_WE_O and STATUS reads 0x001.
